partial_sum_sched: RTL



---
 rtl/partial_sum_sched_if.sv | 25 ++
 rtl/partial_sum_sched.sv | 110 +++++++++++
 2 files changed

// File: rtl/partial_sum_sched_if.sv
// Lane-vector streaming bundle between the partial-sum adder, the multi-pass
// accumulator and the activation/quantise stage (valid/ready on both sides).
interface partial_sum_sched_if #(
   parameter int CH    = 64,
   parameter int IN_W  = 8,
   parameter int ACC_W = 12
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [IN_W-1:0]  in_data [CH];
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_data [CH];

   // master is the surrounding datapath, slave is the accumulator block
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/partial_sum_sched.sv
// Multi-pass saturating accumulator: folds NUM_PASS beats of CH signed lane
// sums into one ACC_W-bit vector and hands it downstream under valid/ready.
module partial_sum_sched #(
   parameter int CH       = 64,
   parameter int IN_W     = 8,
   parameter int ACC_W    = 12,
   parameter int NUM_PASS = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   partial_sum_sched_if.slave   bus,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [7:0]              LAST_PASS = 8'(NUM_PASS - 1);

   state_t                  state;
   state_t                  state_nxt;
   logic [7:0]              pass_cnt;
   logic [7:0]              pass_cnt_nxt;
   logic                    done_nxt;
   logic                    hs;
   logic signed [ACC_W-1:0] acc [CH];

   function automatic logic signed [ACC_W-1:0] sext(input logic signed [IN_W-1:0] v);
      return {{(ACC_W-IN_W){v[IN_W-1]}}, v};
   endfunction

   // One guard bit catches overflow; the two top bits disagree exactly when it happens
   function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [IN_W-1:0]  b);
      logic signed [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {b[IN_W-1], sext(b)};
      if (s[ACC_W] != s[ACC_W-1])
         return s[ACC_W] ? ACC_MIN : ACC_MAX;
      return s[ACC_W-1:0];
   endfunction

   always_comb begin
      state_nxt     = state;
      pass_cnt_nxt  = pass_cnt;
      done_nxt      = 1'b0;
      hs            = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt    = ACCUM;
               pass_cnt_nxt = '0;
            end
         end
         ACCUM: begin
            bus.in_ready = 1'b1;
            hs           = bus.in_valid;
            if (hs) begin
               if (pass_cnt == LAST_PASS) begin
                  state_nxt    = OUTPUT;
                  pass_cnt_nxt = '0;
               end else begin
                  pass_cnt_nxt = pass_cnt + 8'd1;
               end
            end
         end
         OUTPUT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pass_cnt <= '0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         pass_cnt <= pass_cnt_nxt;
         done     <= done_nxt;
      end
   end

   // First beat of a job overwrites the lane, so no separate clear cycle is needed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < CH; k++) acc[k] <= '0;
      end else if (hs) begin
         for (int k = 0; k < CH; k++)
            acc[k] <= (pass_cnt == 8'd0) ? sext(bus.in_data[k]) : sat_add(acc[k], bus.in_data[k]);
      end
   end

   always_comb begin
      for (int k = 0; k < CH; k++) bus.out_data[k] = acc[k];
   end

   assign busy = (state != IDLE);

endmodule
